// File: rtl/booth_mul_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : booth_mul_arbiter_pkg
// Description : Shared types and sizing constants for the multiplier arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package booth_mul_arbiter_pkg;

  localparam int c_nreq    = 4;
  localparam int c_timeout = 32;
  localparam int c_op_w    = 32;
  localparam int c_prod_w  = 64;
  localparam int c_ptr_w   = $clog2(c_nreq);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_LO = 3'd2,
    WAIT_HI = 3'd3,
    RESP    = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/booth_mul_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter4
// Description : Four-way round-robin grant; search begins at ptr and wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter4
  import booth_mul_arbiter_pkg::*;
(
  input  logic [c_nreq-1:0]  req,
  input  logic [c_ptr_w-1:0] ptr,
  output logic [c_nreq-1:0]  grant
);

  logic [c_ptr_w-1:0] w_idx;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    grant = '0;
    w_idx = ptr;
    for (int k = c_nreq - 1; k >= 0; k--) begin
      w_idx = ptr + c_ptr_w'(k);
      if (req[w_idx]) begin
        grant        = '0;
        grant[w_idx] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/booth_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : booth_mul_arbiter
// Description : Shares one external Booth multiplier among four requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_mul_arbiter
  import booth_mul_arbiter_pkg::*;
#(
  parameter int NREQ    = c_nreq,
  parameter int TIMEOUT = c_timeout
) (
  input  logic                     clk,
  input  logic                     async_rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*c_op_w-1:0]   req_a,
  input  logic [NREQ*c_op_w-1:0]   req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [c_ptr_w-1:0]       rsp_id,
  output logic [c_prod_w-1:0]      rsp_r,
  output logic                     rsp_err,
  output logic                     mul_valid,
  output logic [c_op_w-1:0]        mul_a,
  output logic [c_op_w-1:0]        mul_b,
  input  logic [c_prod_w-1:0]      mul_r,
  input  logic                     mul_ready
);

  localparam int                 c_cnt_w   = $clog2(TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(TIMEOUT);

  state_t               r_state, w_state_nxt;
  logic [c_ptr_w-1:0]   r_ptr, r_id, w_grant_id;
  logic [c_cnt_w-1:0]   r_wait_cnt;
  logic [c_op_w-1:0]    r_a, r_b;
  logic [c_prod_w-1:0]  r_rsp_r;
  logic                 r_rsp_err, r_armed;
  logic [NREQ-1:0]      w_grant;
  logic                 w_accept, w_waiting, w_expired, w_done, w_timeout;

  rr_arbiter4 u_rr (
    .req   (req_valid),
    .ptr   (r_ptr),
    .grant (w_grant)
  );

  always_comb begin
    w_grant_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) w_grant_id = c_ptr_w'(i);
    end
  end

  // r_armed keeps req_ready low while reset is held, independent of req_valid.
  assign req_ready = (r_state == IDLE && r_armed) ? w_grant : '0;
  assign w_accept  = |req_ready;
  assign w_waiting = (r_state == WAIT_LO) || (r_state == WAIT_HI);
  assign w_expired = w_waiting && (r_wait_cnt == c_cnt_max);

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = ISSUE;
      ISSUE:   if (mul_ready) w_state_nxt = WAIT_LO;
      WAIT_LO: begin
        if (w_expired) begin
          w_timeout   = 1'b1;
          w_state_nxt = RESP;
        end else if (!mul_ready) begin
          w_state_nxt = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (mul_ready) begin
          w_done      = 1'b1;
          w_state_nxt = RESP;
        end else if (w_expired) begin
          w_timeout   = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP:    if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_state    <= IDLE;
      r_armed    <= 1'b0;
      r_ptr      <= '0;
      r_id       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_wait_cnt <= '0;
      r_rsp_r    <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_armed <= 1'b1;
      if (w_accept) begin
        r_a   <= req_a[int'(w_grant_id)*c_op_w +: c_op_w];
        r_b   <= req_b[int'(w_grant_id)*c_op_w +: c_op_w];
        r_id  <= w_grant_id;
        r_ptr <= w_grant_id + c_ptr_w'(1);
      end
      // Held at zero through ISSUE so the count starts fresh in WAIT_LO.
      if (r_state == ISSUE) begin
        r_wait_cnt <= '0;
      end else if (w_waiting) begin
        r_wait_cnt <= r_wait_cnt + c_cnt_w'(1);
      end
      if (w_done) begin
        r_rsp_r   <= mul_r;
        r_rsp_err <= 1'b0;
      end else if (w_timeout) begin
        r_rsp_r   <= '0;
        r_rsp_err <= 1'b1;
      end
    end
  end

  assign rsp_valid = (r_state == RESP);
  assign rsp_id    = r_id;
  assign rsp_r     = r_rsp_r;
  assign rsp_err   = r_rsp_err;
  assign mul_valid = (r_state == ISSUE);
  assign mul_a     = r_a;
  assign mul_b     = r_b;

endmodule
`default_nettype wire
